// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
//   Shares the single MMIO peripheral bus between two masters:
//   M0 = core LSU, M1 = debug/loader master. Round-robin or fixed-priority
//   arbitration with optional bus locking for bursts, a combinational
//   (stall-capable) grant and a registered one-cycle read response.
//
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_mX_req/we/lock              request, write enable, lock-after-this-grant
//   i_mX_addr/wdata/size          access address, write data, size/funct3
//   o_mX_gnt                      grant, combinational, same cycle as request
//   o_mX_rvalid/rdata             read response, one cycle after the grant
//   o_bus_we/addr/wdata/size      peripheral port, zero while nothing granted
//   i_bus_rdata                   combinational peripheral read data
module mmio_bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8,
    parameter int PRIO_M0   = 0
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic          i_m0_lock,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    input  logic [2:0]    i_m0_size,
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic          i_m1_lock,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    input  logic [2:0]    i_m1_size,
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_bus_we,
    output logic [AW-1:0] o_bus_addr,
    output logic [DW-1:0] o_bus_wdata,
    output logic [2:0]    o_bus_size,
    input  logic [DW-1:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED_M0,
        LOCKED_M1
    } state_t;

    localparam logic [7:0] MAXB    = 8'(MAX_BURST);
    localparam bit         LOCK_EN = (MAX_BURST > 1);

    state_t     state_q, state_d;
    logic       r_last, last_d;      // 0 = M0 won last, 1 = M1 won last
    logic       r_force, force_d;    // one-cycle hand-over after a forced release
    logic [7:0] burst_cnt, cnt_d;
    logic [7:0] cnt_inc;
    logic       gnt0, gnt1;

    assign cnt_inc = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        last_d  = r_last;
        force_d = 1'b0;
        cnt_d   = burst_cnt;
        case (state_q)
            UNLOCKED: begin
                if (i_m0_req && i_m1_req) begin
                    // After a forced release the loser of the burst wins the
                    // tie even under fixed priority; otherwise rotate.
                    if ((PRIO_M0 != 0) && !r_force) gnt0 = 1'b1;
                    else if (r_last)                gnt0 = 1'b1;
                    else                            gnt1 = 1'b1;
                end else begin
                    gnt0 = i_m0_req;
                    gnt1 = i_m1_req;
                end
                if (LOCK_EN && gnt0 && i_m0_lock) begin
                    state_d = LOCKED_M0;
                    cnt_d   = 8'd1;
                end
                if (LOCK_EN && gnt1 && i_m1_lock) begin
                    state_d = LOCKED_M1;
                    cnt_d   = 8'd1;
                end
            end
            LOCKED_M0: begin
                gnt0 = i_m0_req;
                if (!i_m0_req) begin
                    state_d = UNLOCKED;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MAXB) begin
                        state_d = UNLOCKED;
                        force_d = 1'b1;
                    end else if (!i_m0_lock) begin
                        state_d = UNLOCKED;
                    end
                end
            end
            LOCKED_M1: begin
                gnt1 = i_m1_req;
                if (!i_m1_req) begin
                    state_d = UNLOCKED;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MAXB) begin
                        state_d = UNLOCKED;
                        force_d = 1'b1;
                    end else if (!i_m1_lock) begin
                        state_d = UNLOCKED;
                    end
                end
            end
            default: state_d = UNLOCKED;
        endcase
        // No grant is visible while reset is asserted.
        gnt0 = gnt0 & i_rstn;
        gnt1 = gnt1 & i_rstn;
        if (gnt0) last_d = 1'b0;
        if (gnt1) last_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= UNLOCKED;
            r_last    <= 1'b1;
            r_force   <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state_q   <= state_d;
            r_last    <= last_d;
            r_force   <= force_d;
            burst_cnt <= cnt_d;
        end
    end

    assign o_m0_gnt = gnt0;
    assign o_m1_gnt = gnt1;

    always_comb begin
        o_bus_we    = 1'b0;
        o_bus_addr  = '0;
        o_bus_wdata = '0;
        o_bus_size  = '0;
        if (gnt0) begin
            o_bus_we    = i_m0_we;
            o_bus_addr  = i_m0_addr;
            o_bus_wdata = i_m0_wdata;
            o_bus_size  = i_m0_size;
        end else if (gnt1) begin
            o_bus_we    = i_m1_we;
            o_bus_addr  = i_m1_addr;
            o_bus_wdata = i_m1_wdata;
            o_bus_size  = i_m1_size;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_m0_rvalid <= 1'b0;
            o_m1_rvalid <= 1'b0;
            o_m0_rdata  <= '0;
            o_m1_rdata  <= '0;
        end else begin
            o_m0_rvalid <= gnt0 & ~i_m0_we;
            o_m1_rvalid <= gnt1 & ~i_m1_we;
            if (gnt0 && !i_m0_we) o_m0_rdata <= i_bus_rdata;
            if (gnt1 && !i_m1_we) o_m1_rdata <= i_bus_rdata;
        end
    end

endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Shares the single MMIO peripheral bus (output peripherals, timer) between two masters: M0 = core LSU, M1 = debug/loader master.
- Arbitration is round-robin or fixed-priority, with optional bus locking for bursts.
- Provides a stall-capable grant and a registered read-response channel.
- Sits between the LSU MMIO port / debug master and the MMIO read mux / peripheral write port.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 8, maximum consecutive locked grants to one master before forced release. Range 1..255; 1 disables locking.
- PRIO_M0, 0, 1 = M0 wins every unlocked tie; 0 = round-robin.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset
- i_m0_req  in  1  M0 request
- i_m0_we  in  1  M0 write enable
- i_m0_lock  in  1  M0 requests lock after this grant
- i_m0_addr  in  AW  M0 address
- i_m0_wdata  in  DW  M0 write data
- i_m0_size  in  3  M0 access size/funct3
- o_m0_gnt  out  1  M0 granted this cycle
- o_m0_rvalid  out  1  M0 read data valid
- o_m0_rdata  out  DW  M0 read data
- i_m1_req, i_m1_we, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_size, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same meanings for M1
- o_bus_we  out  1  peripheral write strobe
- o_bus_addr  out  AW  peripheral address
- o_bus_wdata  out  DW  peripheral write data
- o_bus_size  out  3  peripheral size
- i_bus_rdata  in  DW  combinational peripheral read data

Behaviour:
- Reset: i_rstn is asynchronous, active-low; clock is i_clk. Reset clears o_mX_gnt, o_mX_rvalid, o_mX_rdata, lock state, burst counter and owner. Round-robin pointer r_last resets to M1, so M0 wins the first tie. o_bus_* read 0 while no grant.
- Grant timing:
  - Grant is combinational in the cycle it is given.
  - At most one gnt is high per cycle. gnt is never high without the matching req.
  - A master holds req/we/addr/wdata/size stable until it sees gnt; M0 stalls the core on req & ~gnt.
- Bus muxing:
  - The bus carries the granted master's addr/wdata/size.
  - o_bus_we = granted master's we.
  - With no grant: o_bus_we=0 and addr/wdata/size=0.
- Writes complete at the clock edge ending the grant cycle. No response is returned.
- Reads:
  - i_bus_rdata is sampled at the edge ending the grant cycle into o_mX_rdata.
  - o_mX_rvalid is high exactly one cycle later (1-cycle latency), then low.
  - o_mX_rdata holds its value until the next read response to that master.
- Throughput: one grant per cycle. Back-to-back reads give back-to-back rvalid.
- State (FSM UNLOCKED / LOCKED_M0 / LOCKED_M1):
  - UNLOCKED:
    - One requester: it wins.
    - Both requesting: PRIO_M0=1 gives M0; otherwise the master != r_last wins.
    - r_last updates to the winner on every grant.
    - Winner with lock=1 and MAX_BURST>1: go to LOCKED_winner, burst_cnt=1.
  - LOCKED_X:
    - Only X may be granted; the other master's req is ignored.
    - Each grant to X increments burst_cnt.
    - Return to UNLOCKED when any of these holds: X's req=0, X's granted lock=0, or burst_cnt reaches MAX_BURST after a grant.
  - Forced release at MAX_BURST: if the other master is requesting, it wins the next cycle regardless of PRIO_M0.
  - burst_cnt is 8 bits. It saturates and never wraps.
- Simultaneous events:
  - Lock release and the other master's req in the same cycle: release takes effect at the edge, the other master is granted next cycle.
  - Reset mid-burst or with an rvalid pending: the response is dropped and the FSM returns to UNLOCKED.

Test Plan:
- Single M0 read, addr 0x1000_2000, i_bus_rdata=0xDEAD_BEEF -> o_m0_gnt=1 same cycle; o_m0_rvalid=1 next cycle with o_m0_rdata=0xDEAD_BEEF; o_m1_* idle.
- Both req every cycle, PRIO_M0=0, no lock -> grants alternate M0,M1,M0,M1…; first grant M0; no cycle has both gnt.
- Same as above with PRIO_M0=1 -> M0 granted every cycle; M1 never granted (documented starvation).
- M1 lock=1 with 12 consecutive write reqs, M0 req held, MAX_BURST=8 -> M1 granted 8 cycles, M0 granted cycle 9, M1 resumes after.
- Lock released early: M0 lock burst of 3 then req=0 while M1 req -> M1 granted the cycle after M0's last grant.
- Assert i_rstn=0 in the cycle after an M1 read grant -> o_m1_rvalid stays 0, all outputs 0, next request arbitrates fresh with M0 winning the tie.
